regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources:
//  req0 (ALU/ALU-immediate) and req1 (load / multi-cycle unit).
//  Each source pushes {addr,data} through a valid/ready handshake into a private FIFO.
//  A round-robin arbiter drains one entry per cycle into a registered write stage
//  that drives RegWrite/RDaddr/RDdata of the register file.
//  Exports a pending-write bitmap for hazard/stall logic in the control unit.
// PARAMETERS
//  DATA_W  32  writeback data width
//  ADDR_W  5   register address width (register count = 2**ADDR_W)
//  DEPTH   2   entries per requester FIFO, power of 2, >=2
// PORTS
//  clk_i        in   1             single clock, all state on posedge
//  rst_i        in   1             asynchronous, active-high reset
//  req0_valid_i in   1             source 0 has a write
//  req0_addr_i  in   ADDR_W        source 0 destination register
//  req0_data_i  in   DATA_W        source 0 write data
//  req0_ready_o out  1             source 0 FIFO can accept
//  req1_valid_i in   1             source 1 has a write
//  req1_addr_i  in   ADDR_W        source 1 destination register
//  req1_data_i  in   DATA_W        source 1 write data
//  req1_ready_o out  1             source 1 FIFO can accept
//  RegWrite_o   out  1             write enable to register file
//  RDaddr_o     out  ADDR_W        write address to register file
//  RDdata_o     out  DATA_W        write data to register file
//  pending_o    out  2**ADDR_W     bit r=1: write to r queued or in write stage
//  idle_o       out  1             both FIFOs empty and RegWrite_o=0
// BEHAVIOUR
//  Reset (async, rst_i=1): FIFOs emptied, pointers 0; RegWrite_o=0, RDaddr_o=0,
//   RDdata_o=0, pending_o=0, idle_o=1, readyN_o=1, last_grant=1 (req0 wins first tie).
//   Reset mid-operation discards all queued writes; no partial write is issued.
//  Handshake: transfer on posedge when reqN_valid_i & reqN_ready_o.
//   reqN_ready_o = !fifoN_full; purely from registered state. A pop in the same
//   cycle does not raise ready. Valid held with ready low: nothing accepted.
//  Address 0: accepted (handshake completes) but not enqueued; never written,
//   pending_o[0] is always 0.
//  Arbitration (comb, per cycle): only fifo0 non-empty -> grant 0; only fifo1 ->
//   grant 1; both -> grant != last_grant; neither -> no grant.
//   On a grant, last_grant updates and the head entry pops at the posedge.
//  Write stage: on posedge, RegWrite_o<=grant_valid; on grant, RDaddr_o/RDdata_o <=
//   head entry; without grant, addr/data hold their value, RegWrite_o=0.
//  Latency: accepted at edge E0 into an empty FIFO with no contention ->
//   RegWrite_o=1 from E1 to E2; register file commits at E2.
//  Throughput: 1 write/cycle total. Under continuous contention, grants alternate 0,1,0,1.
//  Ordering: FIFO order within a source. Between sources, order is grant order;
//   same-address races are resolved by control stalling on pending_o.
//  Simultaneous push and pop on one FIFO: both happen, count unchanged.
//   Push into an empty FIFO is not granted in the same cycle.
//  pending_o: registered, recomputed each posedge as the OR of the one-hot
//   address of every valid FIFO entry and of the write stage when RegWrite_o=1.
//   It is visible the cycle after acceptance and clears the cycle after the commit edge.
//  Counts: ADDR of each FIFO ptr is log2(DEPTH) bits and wraps. Count is
//   log2(DEPTH)+1 bits; full = count==DEPTH; empty = count==0.
// TESTING
//  T1 reset: assert rst_i mid-cycle with 2 entries queued -> outputs 0 at once,
//     pending_o=0, idle_o=1, ready=1. Then no RegWrite_o after release.
//  T2 single: req0 {addr 5, data 32'h1234} at E0 -> RegWrite_o=1, RDaddr_o=5,
//     RDdata_o=32'h1234 during E1..E2; pending_o[5]=1 from E0 through E2.
//  T3 contention: both valid every cycle, req0 addr 1..4, req1 addr 9..12 ->
//     write order 1,9,2,10,3,11,4,12 with no idle cycles.
//  T4 backpressure: DEPTH=2, req1 valid 4 cycles, req0 saturating -> req1_ready_o
//     low once 2 queued; no entry lost or duplicated; data order preserved.
//  T5 $0: req0 writes addr 0, data 32'hDEAD -> handshake completes,
//     RegWrite_o never 1, pending_o stays 0.
//  T6 hazard: req0 addr 7 and req1 addr 7 on the same edge -> req0 commits first,
//     then req1; pending_o[7] is 1 until the edge after req1's commit.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/ready handshakes for two sources plus the register-file write port and status.
// master = writeback sources / register file / control side; slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [(2**ADDR_W)-1:0] pending;
  logic              idle;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, reg_write, rd_addr, rd_data, pending, idle
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, reg_write, rd_addr, rd_data, pending, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source round-robin arbiter for the register-file write port; one write per cycle,
// 2-edge latency from acceptance to commit; ready drops only when that source's FIFO is full.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2 ** ADDR_W;

  logic [ADDR_W-1:0] q_addr [2][DEPTH];
  logic [DATA_W-1:0] q_data [2][DEPTH];
  logic [PW-1:0]     wr_ptr [2];
  logic [PW-1:0]     rd_ptr [2];
  logic [PW-1:0]     rdp_nxt [2];
  logic [CW-1:0]     cnt [2];
  logic [CW-1:0]     cnt_nxt [2];
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_vld, rdy, push, pop, nonempty;
  logic              grant, grant_vld, last_grant;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [NREG-1:0]   pending_nxt;

  assign in_vld     = {bus.req1_valid, bus.req0_valid};
  assign in_addr[0] = bus.req0_addr;
  assign in_addr[1] = bus.req1_addr;
  assign in_data[0] = bus.req0_data;
  assign in_data[1] = bus.req1_data;
  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.idle = (cnt[0] == '0) && (cnt[1] == '0) && !bus.reg_write;

  // Writes to register 0 complete the handshake but are dropped here.
  always_comb begin
    rdy      = '0;
    nonempty = '0;
    push     = '0;
    for (int n = 0; n < 2; n++) begin
      rdy[n]      = (cnt[n] != CW'(DEPTH));
      nonempty[n] = (cnt[n] != '0);
      push[n]     = in_vld[n] & rdy[n] & (in_addr[n] != '0);
    end
  end

  always_comb begin
    grant_vld = |nonempty;
    grant     = 1'b0;
    if (nonempty == 2'b10)
      grant = 1'b1;
    else if (nonempty == 2'b11)
      grant = ~last_grant;
    pop = '0;
    if (grant_vld)
      pop[grant] = 1'b1;
    head_addr = q_addr[grant][rd_ptr[grant]];
    head_data = q_data[grant][rd_ptr[grant]];
    for (int n = 0; n < 2; n++) begin
      cnt_nxt[n] = cnt[n] + CW'(push[n]) - CW'(pop[n]);
      rdp_nxt[n] = rd_ptr[n] + PW'(pop[n]);
    end
  end

  // Bitmap reflects post-edge contents: every occupied slot plus the write stage.
  always_comb begin
    pending_nxt = '0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ({1'b0, PW'(PW'(i) - rdp_nxt[n])} < cnt_nxt[n]) begin
          if (push[n] && (wr_ptr[n] == PW'(i)))
            pending_nxt[in_addr[n]] = 1'b1;
          else
            pending_nxt[q_addr[n][i]] = 1'b1;
        end
      end
    end
    if (grant_vld)
      pending_nxt[head_addr] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        q_addr[n][wr_ptr[n]] <= in_addr[n];
        q_data[n][wr_ptr[n]] <= in_data[n];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        cnt[n]    <= '0;
      end
      last_grant    <= 1'b1;
      bus.reg_write <= 1'b0;
      bus.rd_addr   <= '0;
      bus.rd_data   <= '0;
      bus.pending   <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n])
          wr_ptr[n] <= wr_ptr[n] + PW'(1);
        rd_ptr[n] <= rdp_nxt[n];
        cnt[n]    <= cnt_nxt[n];
      end
      bus.reg_write <= grant_vld;
      if (grant_vld) begin
        last_grant  <= grant;
        bus.rd_addr <= head_addr;
        bus.rd_data <= head_data;
      end
      bus.pending <= pending_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: vector table for single-cycle behaviour, hand-written streams for
// contention, backpressure and mid-operation reset.
module tb_regfile_wb_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int n_checks = 0;
  int n_err = 0;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [31:0] pend;
    logic [2:0]  flags;  // {req0_ready, req1_ready, idle}
  } vec_t;

  vec_t vecs[12];

  int          src0[16];
  int          src1[16];
  int          wr_addr[32];
  logic [31:0] wr_data[32];
  int          wr_cyc[32];
  int          wr_n;
  bit          saw_rdy1_low;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dval(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic drive_idle();
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
  endtask

  // Drives both sources from src0/src1 honouring ready, logging every write-port cycle.
  task automatic run_stream(input int n0, input int n1, input int cycles);
    int i0 = 0;
    int i1 = 0;
    bit f0 = 1'b0;
    bit f1 = 1'b0;
    wr_n = 0;
    saw_rdy1_low = 1'b0;
    for (int k = 0; k < 32; k++) begin
      wr_addr[k] = -1;
      wr_data[k] = '0;
      wr_cyc[k]  = 0;
    end
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      if (bus.reg_write && wr_n < 32) begin
        wr_addr[wr_n] = int'(bus.rd_addr);
        wr_data[wr_n] = bus.rd_data;
        wr_cyc[wr_n]  = c;
        wr_n++;
      end
      if (f0) i0++;
      if (f1) i1++;
      bus.req0_valid = (i0 < n0);
      bus.req0_addr  = (i0 < n0) ? 5'(src0[i0]) : 5'd0;
      bus.req0_data  = (i0 < n0) ? dval(src0[i0]) : 32'd0;
      bus.req1_valid = (i1 < n1);
      bus.req1_addr  = (i1 < n1) ? 5'(src1[i1]) : 5'd0;
      bus.req1_data  = (i1 < n1) ? dval(src1[i1]) : 32'd0;
      if (bus.req1_valid && !bus.req1_ready)
        saw_rdy1_low = 1'b1;
      f0 = bus.req0_valid && bus.req0_ready;
      f1 = bus.req1_valid && bus.req1_ready;
    end
    drive_idle();
  endtask

  initial begin
    int exp3[8];
    int got0[16];
    int got1[16];
    int g0;
    int g1;
    int rw_seen;

    //           v0  a0     d0            v1  a1      d1            rw  ra     rd            pend           flags
    vecs[0]  = '{1'b1, 5'd7,  32'hAAAA_0007, 1'b1, 5'd7,  32'hBBBB_0007, 1'b0, 5'd0,  32'h0,         32'h0000_0080, 3'b110};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'hAAAA_0007, 32'h0000_0080, 3'b110};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'hBBBB_0007, 32'h0000_0080, 3'b110};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd7,  32'hBBBB_0007, 32'h0,         3'b111};
    vecs[4]  = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  32'h0,         1'b0, 5'd7,  32'hBBBB_0007, 32'h0000_0020, 3'b110};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  32'h0000_1234, 32'h0000_0020, 3'b110};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd5,  32'h0000_1234, 32'h0,         3'b111};
    vecs[7]  = '{1'b1, 5'd0,  32'hDEAD,      1'b0, 5'd0,  32'h0,         1'b0, 5'd5,  32'h0000_1234, 32'h0,         3'b111};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd5,  32'h0000_1234, 32'h0,         3'b111};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'hFFFF_0001, 1'b0, 5'd5,  32'h0000_1234, 32'h8000_0000, 3'b110};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'hFFFF_0001, 32'h8000_0000, 3'b110};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd31, 32'hFFFF_0001, 32'h0,         3'b111};

    drive_idle();
    @(negedge clk_i);
    check("reset wb", {bus.reg_write, bus.rd_addr, bus.rd_data}, 64'h0);
    check("reset pending", bus.pending, 64'h0);
    check("reset flags", {bus.req0_ready, bus.req1_ready, bus.idle}, 64'h7);
    rst_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      bus.req0_valid = vecs[i].v0;
      bus.req0_addr  = vecs[i].a0;
      bus.req0_data  = vecs[i].d0;
      bus.req1_valid = vecs[i].v1;
      bus.req1_addr  = vecs[i].a1;
      bus.req1_data  = vecs[i].d1;
      @(negedge clk_i);
      check($sformatf("vec%0d wb", i), {bus.reg_write, bus.rd_addr, bus.rd_data},
            {vecs[i].rw, vecs[i].ra, vecs[i].rd});
      check($sformatf("vec%0d pending", i), bus.pending, vecs[i].pend);
      check($sformatf("vec%0d flags", i), {bus.req0_ready, bus.req1_ready, bus.idle}, vecs[i].flags);
    end
    drive_idle();

    // Contention: strict alternation with the port busy every cycle.
    exp3 = '{1, 9, 2, 10, 3, 11, 4, 12};
    for (int k = 0; k < 4; k++) begin
      src0[k] = k + 1;
      src1[k] = k + 9;
    end
    run_stream(4, 4, 20);
    check("contention count", wr_n, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("contention addr%0d", k), wr_addr[k], exp3[k]);
      check($sformatf("contention data%0d", k), wr_data[k], dval(exp3[k]));
    end
    check("contention gapless", wr_cyc[7] - wr_cyc[0], 7);

    // Backpressure: req1 must stall while its FIFO is full, nothing lost or duplicated.
    for (int k = 0; k < 8; k++) src0[k] = k + 1;
    for (int k = 0; k < 4; k++) src1[k] = k + 16;
    run_stream(8, 4, 40);
    check("bp count", wr_n, 12);
    check("bp req1 ready low", saw_rdy1_low, 1);
    g0 = 0;
    g1 = 0;
    for (int k = 0; k < wr_n && k < 32; k++) begin
      check($sformatf("bp data%0d", k), wr_data[k], dval(wr_addr[k]));
      if (wr_addr[k] < 16) begin
        if (g0 < 16) got0[g0] = wr_addr[k];
        g0++;
      end else begin
        if (g1 < 16) got1[g1] = wr_addr[k];
        g1++;
      end
    end
    check("bp req0 count", g0, 8);
    check("bp req1 count", g1, 4);
    for (int k = 0; k < 8 && k < g0; k++) check($sformatf("bp req0 order%0d", k), got0[k], k + 1);
    for (int k = 0; k < 4 && k < g1; k++) check($sformatf("bp req1 order%0d", k), got1[k], k + 16);
    check("bp drained pending", bus.pending, 64'h0);
    check("bp drained idle", bus.idle, 1);

    // Reset mid-cycle with a write in flight and two entries queued.
    @(negedge clk_i);
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h3333;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h4444;
    @(negedge clk_i);
    bus.req0_addr = 5'd6; bus.req0_data = 32'h6666;
    bus.req1_valid = 1'b0;
    @(negedge clk_i);
    drive_idle();
    check("pre-reset write active", bus.reg_write, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async reset wb", {bus.reg_write, bus.rd_addr, bus.rd_data}, 64'h0);
    check("async reset pending", bus.pending, 64'h0);
    check("async reset flags", {bus.req0_ready, bus.req1_ready, bus.idle}, 64'h7);
    @(negedge clk_i);
    rst_i = 1'b0;
    rw_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (bus.reg_write) rw_seen++;
    end
    check("post-reset no write", rw_seen, 0);
    check("post-reset pending", bus.pending, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
